noc_merge2_arb: RTL and testbench
=================================

Name: noc_merge2_arb

Overview:
- Clocked two-input merge/arbiter stage directly downstream of the leaf address decoders.
- Collects Out0-style flits (9-bit: addr [8:5], payload [4:0]) from two decoder outputs that target the same router port, and serializes them onto one output channel.
- Arbitration is round-robin; the block reports which input each output flit came from, mirroring the decoder's 1-bit select side channel.
- Each input has a small FIFO so a stalled output does not immediately back-pressure the decoders.

Parameters:
- W, 9, flit width in bits; addr field is [W-1:W-4].
- DEPTH, 2, entries per input FIFO; power of two, minimum 2.
- CNT_W, 16, width of per-input flit counters (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in0_data  in  W  flit from input 0.
- in0_valid  in  1  input 0 flit present.
- in0_ready  out  1  input 0 FIFO can accept.
- in1_data  in  W  flit from input 1.
- in1_valid  in  1  input 1 flit present.
- in1_ready  out  1  input 1 FIFO can accept.
- out_data  out  W  merged flit.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_src  out  1  source of current out_data: 0 = in0, 1 = in1.
- cnt0, cnt1  out  CNT_W  forwarded-flit counts (present only with MERGE_STATS_EN).

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - Both FIFOs empty; all FIFO pointers 0.
  - out_valid=0, out_data=0, out_src=0.
  - last_grant=1, so in0 wins the first contested arbitration.
  - in0_ready=in1_ready=1 once rst_n is high.
- Input handshake:
  - Push occurs when inX_valid && inX_ready at the clock edge.
  - inX_ready = !fullX, registered-state only; it does not depend on a same-cycle pop.
  - A full FIFO refuses the push even if it is also popped that cycle.
- FIFOs: circular buffer with (log2(DEPTH)+1)-bit read/write pointers.
  - empty when pointers are equal.
  - full when the MSBs differ and the lower bits are equal.
  - Pointers wrap naturally.
- Output register:
  - "Free" = !out_valid || out_ready.
  - When free and at least one FIFO is non-empty, the block pops the granted FIFO and loads out_data/out_src, with out_valid=1.
  - When free and both FIFOs are empty, out_valid goes to 0.
  - While out_valid && !out_ready, out_data and out_src are held stable and no pop occurs.
- Arbitration, evaluated only when the output is free:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant !last_grant.
  - last_grant updates on every grant.
- Latency and throughput:
  - A flit pushed into an empty FIFO at edge N is presented at edge N+1 if the output is free; zero-bubble bypass is not supported.
  - Sustained throughput is 1 flit/cycle.
  - Under both-input saturation, output alternates 0,1,0,1.
- Simultaneous events:
  - Push and pop on the same non-full FIFO in one cycle are both performed; occupancy is unchanged.
  - Push into an empty FIFO is not eligible for arbitration until the next cycle.
- Data is passed through unmodified; the block performs no address checking.
- Reset mid-operation discards all buffered flits and any flit held on the output; no partial handshake is retained.

Optional Feature:
- Macro: MERGE_STATS_EN.
- Defined:
  - cnt0 and cnt1 ports exist.
  - Each counter increments by 1 on every out_valid && out_ready cycle whose out_src matches.
  - Counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counters; cnt0/cnt1 ports are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst_n low mid-transfer with both FIFOs full -> out_valid=0, in0_ready=in1_ready=1 the cycle after release; no stale flit emitted.
- Single flit: in0 sends 9'h1A3, out_ready=1 -> next cycle out_valid=1, out_data=9'h1A3, out_src=0; one cycle later out_valid=0.
- Contention: both inputs stream 4 flits each (in0 9'h180..183, in1 9'h0C0..0C3), out_ready=1 -> output order 180,0C0,181,0C1,182,0C2,183,0C3, with out_src alternating 0,1 starting at 0.
- Back-pressure: out_ready=0 for 5 cycles while in1 streams -> in1_ready drops after DEPTH+1 accepted flits; out_data holds stable; after out_ready=1 all flits are delivered in order with none lost or duplicated.
- Wrap-around: 3*DEPTH flits through in0 with random out_ready -> exact in-order delivery; FIFO pointers wrap; full/empty flags correct throughout.
- With MERGE_STATS_EN: 7 flits via in0 and 5 via in1 -> cnt0=7, cnt1=5; with CNT_W=3, 9 flits on in0 -> cnt0=1.

Source files
------------

// File: rtl/noc_merge2_arb.sv
// noc_merge2_arb: two-input round-robin merge stage for 9-bit decoder flits.
// Each input owns a small circular FIFO; a single output register presents
// the merged flit together with a 1-bit source tag (0 = in0, 1 = in1).
// Optional build macro: MERGE_STATS_EN adds per-source forwarded-flit
// counters cnt0/cnt1 (CNT_W bits, wrapping).
module noc_merge2_arb #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [W-1:0]     in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src
`ifdef MERGE_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [W-1:0]  mem0_q [DEPTH];
  logic [W-1:0]  mem1_q [DEPTH];
  logic [PW-1:0] wr0_q, rd0_q, wr1_q, rd1_q;

  // Output register and arbitration history
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_src_q, out_src_d;
  logic          last_grant_q, last_grant_d;

  logic          empty0_s, empty1_s, full0_s, full1_s;
  logic          push0_s, push1_s, pop0_s, pop1_s;
  logic          free_s, grant_s;
  logic [W-1:0]  head0_s, head1_s;

  assign empty0_s = (wr0_q == rd0_q);
  assign empty1_s = (wr1_q == rd1_q);
  assign full0_s  = (wr0_q[AW] != rd0_q[AW]) && (wr0_q[AW-1:0] == rd0_q[AW-1:0]);
  assign full1_s  = (wr1_q[AW] != rd1_q[AW]) && (wr1_q[AW-1:0] == rd1_q[AW-1:0]);

  // Ready reflects stored occupancy only; a same-cycle pop never frees a slot early.
  assign in0_ready = !full0_s;
  assign in1_ready = !full1_s;
  assign push0_s   = in0_valid && !full0_s;
  assign push1_s   = in1_valid && !full1_s;

  assign head0_s = mem0_q[rd0_q[AW-1:0]];
  assign head1_s = mem1_q[rd1_q[AW-1:0]];
  assign free_s  = !out_valid_q || out_ready;

  // Round-robin grant and pop selection, only while the output register can load
  always_comb begin
    grant_s = 1'b0;
    pop0_s  = 1'b0;
    pop1_s  = 1'b0;
    if (free_s) begin
      if (!empty0_s && !empty1_s) begin
        grant_s = !last_grant_q;
      end else if (!empty0_s) begin
        grant_s = 1'b0;
      end else begin
        grant_s = 1'b1;
      end
      pop0_s = !grant_s && !empty0_s;
      pop1_s = grant_s && !empty1_s;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state for the output register and last grant
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (pop0_s || pop1_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = pop1_s ? head1_s : head0_s;
      out_src_d    = pop1_s;
      last_grant_d = pop1_s;
    end else if (free_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FIFO storage writes (contents need no reset; pointers gate visibility)
  always_ff @(posedge clk) begin
    if (push0_s) mem0_q[wr0_q[AW-1:0]] <= in0_data;
    if (push1_s) mem1_q[wr1_q[AW-1:0]] <= in1_data;
  end

  // FIFO pointers, output register and arbitration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0_q        <= '0;
      rd0_q        <= '0;
      wr1_q        <= '0;
      rd1_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (push0_s) wr0_q <= wr0_q + PTR_ONE;
      if (pop0_s)  rd0_q <= rd0_q + PTR_ONE;
      if (push1_s) wr1_q <= wr1_q + PTR_ONE;
      if (pop1_s)  rd1_q <= rd1_q + PTR_ONE;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

`ifdef MERGE_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Count flits actually accepted downstream, per source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (out_src_q) cnt1_q <= cnt1_q + CNT_W'(1);
      else           cnt0_q <= cnt0_q + CNT_W'(1);
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_noc_merge2_arb.sv
// Self-checking bench for noc_merge2_arb: per-source scoreboards fed on input
// acceptance, checked on every output transfer.
module tb_noc_merge2_arb;

  localparam int W     = 9;
  localparam int DEPTH = 2;
`ifdef MERGE_STATS_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in0_data = '0, in1_data = '0;
  logic         in0_valid = 1'b0, in1_valid = 1'b0;
  logic         in0_ready, in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid, out_src;
  logic         out_ready = 1'b0;
`ifdef MERGE_STATS_EN
  logic [CNT_W-1:0] cnt0, cnt1;
`endif

  noc_merge2_arb #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef MERGE_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W:0]   exp_q[$];
  logic         acc0, acc1, fired, fired_src;
  logic [W-1:0] fired_data;

  // Apply one cycle of stimulus from a negedge; record accepted pushes and the
  // output transfer that the coming posedge will perform.
  task automatic drive(input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic ordy);
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = ordy;
    acc0 = v0 && in0_ready;
    acc1 = v1 && in1_ready;
    if (acc0) q0.push_back(d0);
    if (acc1) q1.push_back(d1);
    fired      = out_valid && ordy;
    fired_data = out_data;
    fired_src  = out_src;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 9'h000 || out_src !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: valid=%b data=%h src=%b, required 0/000/0", out_valid, out_data, out_src);
    end
    vectors++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: in0_ready=%b in1_ready=%b, required 1/1", in0_ready, in1_ready);
    end
    // fill both FIFOs while the output is stalled
    for (int i = 0; i < 6; i++) drive(1'b1, 9'h100 + 9'(i), 1'b1, 9'h010 + 9'(i), 1'b0);
    vectors++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_before_reset: in0_ready=%b in1_ready=%b out_valid=%b, required 0/0/1", in0_ready, in1_ready, out_valid);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 9'h000) begin
      miscompares++;
      $display("FAIL async_reset: out_valid=%b out_data=%h, required 0/000", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    vectors++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_release: in0_ready=%b in1_ready=%b out_valid=%b, required 1/1/0", in0_ready, in1_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_flit: out_valid=%b data=%h, required valid 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 9'h1A3, 1'b0, 9'h000, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_bypass: out_valid=%b, required 0", out_valid);
    end
    drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 9'h1A3 || out_src !== 1'b0) begin
      miscompares++;
      $display("FAIL single_out: valid=%b data=%h src=%b, required 1/1a3/0", out_valid, out_data, out_src);
    end
    drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drop: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_contention();
    int i0, i1, got;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 9'h180 + 9'(k)});
      exp_q.push_back({1'b1, 9'h0C0 + 9'(k)});
    end
    i0 = 0; i1 = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      drive(i0 < 4, 9'h180 + 9'(i0), i1 < 4, 9'h0C0 + 9'(i1), 1'b1);
      if (acc0) i0++;
      if (acc1) i1++;
      if (fired) begin
        logic [W:0] e;
        e = exp_q.pop_front();
        got++;
        vectors++;
        if ({fired_src, fired_data} !== e) begin
          miscompares++;
          $display("FAIL contention_order[%0d]: src=%b data=%h, required src=%b data=%h", got, fired_src, fired_data, e[W], e[W-1:0]);
        end
      end
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL contention_count: got %0d flits, required 8", got);
    end
  endtask

  task automatic test_back_to_back();
    int accepted, got;
    do_reset();
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 9'h000, 1'b1, 9'h040 + 9'(accepted), 1'b0);
      if (acc1) accepted++;
      if (out_valid === 1'b1) begin
        vectors++;
        if (out_data !== 9'h040 || out_src !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold: data=%h src=%b, required 040/1", out_data, out_src);
        end
      end
    end
    vectors++;
    if (accepted != DEPTH + 1 || in1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure: accepted=%0d in1_ready=%b, required %0d/0", accepted, in1_ready, DEPTH + 1);
    end
    got = 0;
    for (int c = 0; c < 20 && got < accepted; c++) begin
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
      if (fired) begin
        got++;
        vectors++;
        if (fired_src !== 1'b1 || q1.size() == 0 || fired_data !== q1[0]) begin
          miscompares++;
          $display("FAIL drain[%0d]: src=%b data=%h, required src 1 data %h", got, fired_src, fired_data, (q1.size() != 0) ? q1[0] : 9'h000);
        end
        if (q1.size() != 0) void'(q1.pop_front());
      end
    end
    vectors++;
    if (got != accepted || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_count: got %0d out_valid=%b, required %0d/0", got, out_valid, accepted);
    end
  endtask

  task automatic test_wrap();
    int sent, got, occ;
    logic ov, v, r, push, pop, fr;
    do_reset();
    sent = 0; got = 0; occ = 0; ov = 1'b0;
    for (int c = 0; c < 200 && got < 3 * DEPTH; c++) begin
      vectors++;
      if (in0_ready !== (occ != DEPTH) || out_valid !== ov) begin
        miscompares++;
        $display("FAIL wrap_flags: in0_ready=%b out_valid=%b, required %b/%b", in0_ready, out_valid, occ != DEPTH, ov);
      end
      v = (sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) == 1);
      push = v && (occ < DEPTH);
      fr   = !ov || r;
      pop  = fr && (occ > 0);
      drive(v, 9'h0A0 + 9'(sent), 1'b0, 9'h000, r);
      if (acc0) sent++;
      if (fired) begin
        got++;
        vectors++;
        if (fired_src !== 1'b0 || q0.size() == 0 || fired_data !== q0[0]) begin
          miscompares++;
          $display("FAIL wrap_data[%0d]: src=%b data=%h, required src 0 data %h", got, fired_src, fired_data, (q0.size() != 0) ? q0[0] : 9'h000);
        end
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (fr) ov = (occ > 0);
      occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
    end
    vectors++;
    if (got != 3 * DEPTH) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d flits, required %0d", got, 3 * DEPTH);
    end
  endtask

`ifdef MERGE_STATS_EN
  task automatic test_stats();
    int n0, n1, s0, s1;
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      n0 = (phase == 0) ? 7 : 9;
      n1 = (phase == 0) ? 5 : 0;
      s0 = 0; s1 = 0;
      for (int c = 0; c < 80; c++) begin
        drive(s0 < n0, 9'h1F0 + 9'(s0), s1 < n1, 9'h020 + 9'(s1), 1'b1);
        if (acc0) s0++;
        if (acc1) s1++;
      end
      vectors++;
      if (cnt0 !== CNT_W'(n0) || cnt1 !== CNT_W'(n1)) begin
        miscompares++;
        $display("FAIL stats_phase%0d: cnt0=%0d cnt1=%0d, required %0d/%0d", phase, cnt0, cnt1, n0 % 8, n1 % 8);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_wrap();
`ifdef MERGE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
